// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the circle sprite renderer.
//   H_ACTIVE / V_ACTIVE : visible raster size
//   SPR_SIZE            : sprite edge length, fixed by the 64x64 circle ROM
//   rgb_t               : 8/8/8 colour triple
//   pos_t               : 10-bit sprite top-left position
package vga_pkg;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned SPR_SIZE = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;
endpackage

// File: rtl/circle_sprite_renderer_if.sv
// Sprite position update channel (valid/ready).
//   pos_valid : a new position is offered
//   pos_x/y   : offered left column / top line
//   pos_ready : receiver's pending buffer is empty
// master = producer of positions, slave = the renderer.
interface circle_sprite_renderer_if;
  logic       pos_valid;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       pos_ready;

  modport master (output pos_valid, pos_x, pos_y, input pos_ready);
  modport slave  (input pos_valid, pos_x, pos_y, output pos_ready);
endinterface

// File: rtl/sprite_pos_buffer.sv
// Double-buffered sprite position.
//   clk, rst_n  : clock, async active-low reset
//   frame_start : pixel tick at raster (0,0); pending moves to active here
//   pos         : valid/ready position channel (slave side)
//   act_pos     : position used by the raster pipeline
// An offer is accepted only into an empty pending slot; commit and accept
// are mutually exclusive because both depend on the slot state.
import vga_pkg::*;

module sprite_pos_buffer #(
  parameter logic [9:0] RESET_X = 10'd288,
  parameter logic [9:0] RESET_Y = 10'd208
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  circle_sprite_renderer_if.slave  pos,
  output pos_t                     act_pos
);

  pos_t act_q, act_d;
  pos_t pend_q, pend_d;
  logic ready_q, ready_d;

  always_comb begin
    act_d   = act_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    if (!ready_q && frame_start) begin
      act_d   = pend_q;
      ready_d = 1'b1;
    end else if (ready_q && pos.pos_valid) begin
      pend_d  = '{x: pos.pos_x, y: pos.pos_y};
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= '{x: RESET_X, y: RESET_Y};
      pend_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      act_q   <= act_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  assign pos.pos_ready = ready_q;
  assign act_pos       = act_q;

endmodule

// File: rtl/circle_sprite_renderer.sv
// Circle sprite renderer: raster position -> ROM row fetch -> RGB.
//   clk, rst_n           : clock, async active-low reset
//   pix_en               : pixel tick; the pipeline only advances on it
//   hcount/vcount        : raster position from the sync generator
//   video_on, hsync_in, vsync_in : sync generator timing (syncs active-low)
//   pos                  : double-buffered sprite position channel
//   rom_addr / rom_data  : circle ROM row address / combinational row word
//   red/green/blue       : pixel colour, 2 ticks after the raster inputs
//   hsync_out/vsync_out/blank_n : timing delayed to match RGB
//   hit                  : output pixel is a lit sprite pixel
import vga_pkg::*;

module circle_sprite_renderer #(
  parameter logic [23:0] FG_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter logic [9:0]  RESET_X  = 10'd288,
  parameter logic [9:0]  RESET_Y  = 10'd208
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_en,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     video_on,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  circle_sprite_renderer_if.slave  pos,
  output logic [5:0]               rom_addr,
  input  logic [63:0]              rom_data,
  output logic [7:0]               red,
  output logic [7:0]               green,
  output logic [7:0]               blue,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     blank_n,
  output logic                     hit
);

  localparam logic [10:0] SPR_W = 11'(SPR_SIZE);

  pos_t act;
  logic frame_start;

  assign frame_start = pix_en && (hcount == '0) && (vcount == '0);

  sprite_pos_buffer #(
    .RESET_X (RESET_X),
    .RESET_Y (RESET_Y)
  ) u_pos_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pos         (pos),
    .act_pos     (act)
  );

  // Stage 1 window test in 11 bits so act+SPR_SIZE never wraps.
  logic [10:0] h_w, v_w, ax_w, ay_w;
  logic        in_spr_w;

  always_comb begin
    h_w      = {1'b0, hcount};
    v_w      = {1'b0, vcount};
    ax_w     = {1'b0, act.x};
    ay_w     = {1'b0, act.y};
    in_spr_w = (h_w >= ax_w) && (h_w < ax_w + SPR_W) &&
               (v_w >= ay_w) && (v_w < ay_w + SPR_W);
  end

  logic [5:0] rom_addr_q, rom_addr_d, col_q, col_d;
  logic       in_spr_q, in_spr_d, vid1_q, vid1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  rgb_t       rgb_q, rgb_d;
  logic       hit_q, hit_d, hs2_q, hs2_d, vs2_q, vs2_d, blank_q, blank_d;
  logic       lit;

  assign lit = in_spr_q && vid1_q && rom_data[6'd63 - col_q];

  always_comb begin
    rom_addr_d = rom_addr_q;
    col_d      = col_q;
    in_spr_d   = in_spr_q;
    vid1_d     = vid1_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    rgb_d      = rgb_q;
    hit_d      = hit_q;
    hs2_d      = hs2_q;
    vs2_d      = vs2_q;
    blank_d    = blank_q;
    if (pix_en) begin
      // Only the low 6 bits of dx/dy are kept, and those depend only on
      // the low 6 bits of the operands.
      rom_addr_d = vcount[5:0] - act.y[5:0];
      col_d      = hcount[5:0] - act.x[5:0];
      in_spr_d   = in_spr_w;
      vid1_d     = video_on;
      hs1_d      = hsync_in;
      vs1_d      = vsync_in;
      rgb_d      = lit ? rgb_t'(FG_COLOR) : (vid1_q ? rgb_t'(BG_COLOR) : '0);
      hit_d      = lit;
      hs2_d      = hs1_q;
      vs2_d      = vs1_q;
      blank_d    = vid1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      col_q      <= '0;
      in_spr_q   <= 1'b0;
      vid1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      rgb_q      <= '0;
      hit_q      <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      blank_q    <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      in_spr_q   <= in_spr_d;
      vid1_q     <= vid1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      rgb_q      <= rgb_d;
      hit_q      <= hit_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      blank_q    <= blank_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign red       = rgb_q.r;
  assign green     = rgb_q.g;
  assign blue      = rgb_q.b;
  assign hit       = hit_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign blank_n   = blank_q;

endmodule

// File: tb/tb_circle_sprite_renderer.sv
module tb_circle_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [9:0]  hcount, vcount;
  logic        video_on, hsync_in, vsync_in;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic [7:0]  red, green, blue;
  logic        hsync_out, vsync_out, blank_n, hit;

  int tests = 0;
  int fails = 0;

  circle_sprite_renderer_if pif();

  circle_sprite_renderer #(
    .FG_COLOR (24'hFF0000),
    .BG_COLOR (24'h000000),
    .RESET_X  (10'd288),
    .RESET_Y  (10'd208)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .hcount    (hcount),
    .vcount    (vcount),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .pos       (pif),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_n   (blank_n),
    .hit       (hit)
  );

  always #5 clk = ~clk;

  // Circle ROM: pixel (r,c) lit when its centre lies inside radius 32.
  function automatic bit circ(int r, int c);
    int a, b;
    a = 2 * c - 63;
    b = 2 * r - 63;
    return (a * a + b * b) <= 4096;
  endfunction

  function automatic logic [63:0] rom_row(int r);
    logic [63:0] w;
    w = '0;
    for (int c = 0; c < 64; c++) w[63 - c] = circ(r, c);
    return w;
  endfunction

  always_comb rom_data = rom_row(int'(rom_addr));

  // Behavioural model: position bookkeeping plus a 2-tick output delay.
  typedef struct packed {
    logic [23:0] rgb;
    logic        hit;
    logic        hs;
    logic        vs;
    logic        blank;
  } exp_t;

  localparam exp_t EXP_RST = '{rgb: 24'h0, hit: 1'b0, hs: 1'b1, vs: 1'b1, blank: 1'b0};

  int         m_ax, m_ay, m_px, m_py;
  bit         m_full;
  exp_t       e_mid, e_out;
  logic [5:0] e_addr;

  function automatic exp_t pixel(int h, int v, bit vid, bit hs, bit vs, int ax, int ay);
    exp_t e;
    int dx, dy;
    bit lit;
    dx = h - ax;
    dy = v - ay;
    lit = vid && dx >= 0 && dx < 64 && dy >= 0 && dy < 64 && circ(dy, dx);
    e.rgb   = lit ? 24'hFF0000 : 24'h000000;
    e.hit   = lit;
    e.hs    = hs;
    e.vs    = vs;
    e.blank = vid;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ax = 288; m_ay = 208; m_px = 0; m_py = 0; m_full = 0;
      e_mid = EXP_RST; e_out = EXP_RST; e_addr = '0;
    end else begin
      if (pix_en) begin
        e_out  = e_mid;
        e_mid  = pixel(int'(hcount), int'(vcount), video_on, hsync_in, vsync_in, m_ax, m_ay);
        e_addr = 6'((int'(vcount) - m_ay) & 63);
      end
      if (m_full && pix_en && hcount == 0 && vcount == 0) begin
        m_ax = m_px; m_ay = m_py; m_full = 0;
      end else if (!m_full && pif.pos_valid) begin
        m_px = int'(pif.pos_x); m_py = int'(pif.pos_y); m_full = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      tests++;
      if ({red, green, blue} !== e_out.rgb || hit !== e_out.hit || hsync_out !== e_out.hs ||
          vsync_out !== e_out.vs || blank_n !== e_out.blank || rom_addr !== e_addr ||
          pif.pos_ready !== !m_full) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got rgb=%h hit=%b hs=%b vs=%b bl=%b addr=%0d rdy=%b want rgb=%h hit=%b hs=%b vs=%b bl=%b addr=%0d rdy=%b",
                 $time, {red, green, blue}, hit, hsync_out, vsync_out, blank_n, rom_addr, pif.pos_ready,
                 e_out.rgb, e_out.hit, e_out.hs, e_out.vs, e_out.blank, e_addr, !m_full);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic tick(int h, int v, bit vid, bit hs = 1'b1, bit vs = 1'b1);
    @(negedge clk);
    pix_en = 1'b1; hcount = 10'(h); vcount = 10'(v);
    video_on = vid; hsync_in = hs; vsync_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; hcount = '0; vcount = '0;
    video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    pif.pos_valid = 1'b0; pif.pos_x = '0; pif.pos_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'd1);
    chk("rst_vs", 32'(vsync_out), 32'd1);
    chk("rst_ready", 32'(pif.pos_ready), 32'd1);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_blank", 32'(blank_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset position, centre pixel lit
    tick(0, 0, 1);
    tick(320, 240, 1);
    chk("ctr_addr", 32'(rom_addr), 32'd32);
    tick(321, 240, 1);
    chk("ctr_red", 32'(red), 32'hFF);
    chk("ctr_hit", 32'(hit), 32'd1);
    for (int h = 280; h < 360; h++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      tick(h, 240, 1, (h % 7) != 3, (h % 11) != 5);
    end

    // Mid-frame offer of (100,50) takes effect at next frame start
    pif.pos_valid = 1'b1; pif.pos_x = 10'd100; pif.pos_y = 10'd50;
    tick(400, 240, 1);
    pif.pos_valid = 1'b0;
    chk("offer_ready_low", 32'(pif.pos_ready), 32'd0);
    tick(126, 50, 1);
    tick(127, 50, 1);
    chk("old_pos_hit", 32'(hit), 32'd0);
    tick(0, 0, 1);
    chk("commit_ready", 32'(pif.pos_ready), 32'd1);
    tick(126, 50, 1);
    tick(127, 50, 1);
    chk("new_pos_hit", 32'(hit), 32'd1);
    chk("new_pos_red", 32'(red), 32'hFF);

    // Valid held across two offers: (10,10) then (20,20)
    pif.pos_valid = 1'b1; pif.pos_x = 10'd10; pif.pos_y = 10'd10;
    tick(200, 100, 1);
    chk("two_first_acc", 32'(pif.pos_ready), 32'd0);
    pif.pos_x = 10'd20; pif.pos_y = 10'd20;
    tick(201, 100, 1);
    tick(202, 100, 1);
    chk("two_wait", 32'(pif.pos_ready), 32'd0);
    tick(0, 0, 1);
    chk("two_commit1", 32'(pif.pos_ready), 32'd1);
    tick(1, 0, 1);
    chk("two_second_acc", 32'(pif.pos_ready), 32'd0);
    pif.pos_valid = 1'b0;
    tick(36, 10, 1);
    tick(80, 40, 1);
    chk("f10_hit", 32'(hit), 32'd1);
    tick(81, 40, 1);
    chk("f10_miss", 32'(hit), 32'd0);

    // Commit with a new offer waiting: commit only, offer taken afterwards
    pif.pos_valid = 1'b1; pif.pos_x = 10'd600; pif.pos_y = 10'd450;
    tick(0, 0, 1);
    chk("full_fs_ready", 32'(pif.pos_ready), 32'd1);
    tick(1, 0, 1);
    chk("full_fs_acc", 32'(pif.pos_ready), 32'd0);
    pif.pos_valid = 1'b0;
    tick(36, 10, 1);
    tick(80, 40, 1);
    chk("f20_miss", 32'(hit), 32'd0);
    tick(81, 40, 1);
    chk("f20_hit", 32'(hit), 32'd1);

    // Bottom-right clipping at (600,450)
    tick(0, 0, 1);
    for (int h = 590; h < 650; h++) tick(h, 470, h < 640);
    tick(639, 479, 1);
    chk("clip_addr", 32'(rom_addr), 32'd29);
    tick(640, 479, 0);
    chk("clip_edge_hit", 32'(hit), 32'd1);
    tick(641, 479, 0);
    chk("clip_off_red", 32'(red), 32'd0);
    chk("clip_off_blank", 32'(blank_n), 32'd0);

    // Offer in the frame-start cycle with empty pending: next frame
    pif.pos_valid = 1'b1; pif.pos_x = 10'd700; pif.pos_y = 10'd500;
    tick(0, 0, 1);
    pif.pos_valid = 1'b0;
    chk("fs_offer_stored", 32'(pif.pos_ready), 32'd0);
    tick(639, 479, 1);
    tick(640, 479, 0);
    chk("fs_offer_old", 32'(hit), 32'd1);
    tick(0, 0, 1);
    chk("fs_offer_commit", 32'(pif.pos_ready), 32'd1);
    for (int v = 470; v < 480; v += 3)
      for (int h = 600; h < 640; h += 2) tick(h, v, 1);
    tick(639, 479, 1);
    tick(638, 479, 1);
    chk("offscr_hit", 32'(hit), 32'd0);
    chk("offscr_blank", 32'(blank_n), 32'd1);
    chk("offscr_rgb", {8'h0, red, green, blue}, 32'h0);

    // Sprite at (0,0)
    pif.pos_valid = 1'b1; pif.pos_x = 10'd0; pif.pos_y = 10'd0;
    tick(5, 5, 1);
    pif.pos_valid = 1'b0;
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(26, 0, 1);
    chk("corner_bg", 32'(hit), 32'd0);
    tick(27, 0, 1);
    chk("corner_fg_hit", 32'(hit), 32'd1);
    chk("corner_fg_red", 32'(red), 32'hFF);
    for (int h = 0; h < 64; h++) begin
      if ($urandom_range(0, 2) == 0) idle(2);
      tick(h, 32, 1, h > 8);
    end

    // Asynchronous reset mid-line
    tick(30, 32, 1);
    tick(31, 32, 1);
    chk("pre_rst_hit", 32'(hit), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("arst_hit", 32'(hit), 32'd0);
    chk("arst_blank", 32'(blank_n), 32'd0);
    chk("arst_hs", 32'(hsync_out), 32'd1);
    chk("arst_ready", 32'(pif.pos_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(320, 240, 1);
    tick(321, 240, 1);
    chk("arst_pos_hit", 32'(hit), 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circle_sprite_renderer.md
Name: circle_sprite_renderer

Overview:
- Downstream consumer of the 64x64 circle bitmap ROM (6-bit row address, 64-bit row word; MSB = leftmost pixel).
- Sits between the VGA sync generator and the DAC pins. It takes the raster position, drives the ROM row address, selects the pixel bit and outputs RGB with syncs delay-matched.
- Sprite position updates arrive over a valid/ready handshake and are double-buffered, so they take effect only at frame start (no tearing).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPR_SIZE, 64, sprite width/height; fixed by the ROM geometry
- FG_COLOR, 24'hFF0000, RGB888 colour for ROM bit = 1
- BG_COLOR, 24'h000000, RGB888 colour for ROM bit = 0 or outside the sprite
- RESET_X, 288, sprite left column after reset (centred)
- RESET_Y, 208, sprite top line after reset (centred)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-rate tick (25 MHz enable); the pipeline advances only on ticks
- hcount  in  10  current pixel column from the sync generator
- vcount  in  10  current line from the sync generator
- video_on  in  1  high inside the visible area
- hsync_in  in  1  active-low hsync from the sync generator
- vsync_in  in  1  active-low vsync from the sync generator
- pos_valid  in  1  a new sprite position is offered
- pos_x  in  10  new left column
- pos_y  in  10  new top line
- pos_ready  out  1  pending buffer empty; handshake may complete
- rom_addr  out  6  row address to the circle ROM
- rom_data  in  64  combinational row word from the ROM
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- hsync_out  out  1  hsync delayed to align with RGB
- vsync_out  out  1  vsync delayed to align with RGB
- blank_n  out  1  delayed video_on
- hit  out  1  high while the output pixel is a lit sprite pixel

Behaviour:
- Reset (async, rst_n=0):
  - Active position = (RESET_X, RESET_Y); pending empty; pos_ready=1.
  - rom_addr=0; red/green/blue=0; hit=0; blank_n=0; hsync_out=1; vsync_out=1.
- Handshake:
  - Transfer occurs when pos_valid & pos_ready at a clk edge (independent of pix_en).
  - On transfer, pending <= {pos_x,pos_y} and pos_ready drops to 0 on the next cycle.
  - pos_ready is a registered output.
- Commit:
  - frame_start = pix_en & hcount==0 & vcount==0.
  - If pending is full at frame_start: active <= pending, pending cleared, pos_ready=1 next cycle.
  - A transfer in the same cycle as frame_start with pending empty is stored in pending and commits at the next frame.
  - Pending full plus frame_start plus pos_valid: commit only; the new offer waits (ready was 0).
- Stage 1 (registered on pix_en):
  - dx = hcount - act_x and dy = vcount - act_y, computed in 11-bit unsigned.
  - in_spr = (hcount >= act_x) & (hcount < act_x+SPR_SIZE) & same test for y; use 11-bit compares, no wrap.
  - Register rom_addr <= dy[5:0], col <= dx[5:0], in_spr, video_on, hsync_in, vsync_in.
- Stage 2 (registered on pix_en):
  - bit = rom_data[63 - col].
  - lit = in_spr_d & vid_d & bit.
  - RGB = lit ? FG_COLOR : (vid_d ? BG_COLOR : 0).
  - hit = lit; syncs and blank_n take their stage-1 copies.
- Latency: exactly 2 pix_en ticks from hcount/vcount/syncs to RGB/syncs; all outputs stay mutually aligned.
- Clipping:
  - Sprites crossing the right/bottom edge are clipped by video_on.
  - act_x >= H_ACTIVE or act_y >= V_ACTIVE is legal; the sprite is simply invisible.
- No pix_en: all pipeline registers hold; the handshake still operates.
- Reset mid-frame: outputs go to reset values immediately and the active position returns to RESET_X/RESET_Y.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, SPR_SIZE constants.
  - typedef rgb_t (8/8/8 struct).
  - typedef pos_t (10-bit x, 10-bit y).
- One sub-module, sprite_pos_buffer, holds the active/pending registers, the handshake and frame_start commit. The renderer instantiates it plus the two pipeline stages.

Test Plan:
- Reset → RGB=0, hsync_out=vsync_out=1, pos_ready=1. At hcount=288+32, vcount=208+32 (after a 2-tick delay) red=FF, hit=1.
- Offer (100,50) mid-frame → pos_ready=0 the next cycle. The sprite stays at (288,208) until frame_start, then (100,50,row 0,col 26 → ROM bit 1) is lit in the next frame; pos_ready=1.
- pos_valid held through two offers (10,10) then (20,20) → second accepted only after the frame_start commit of the first. Frames show (10,10) then (20,20).
- Position (600,450) → columns 600..639 drawn, nothing at hcount≥640 (video_on=0 gives RGB=0). Row addr for vcount=479 is 29.
- Position (700,500) → no hit anywhere in the frame; visible area shows BG_COLOR.
- Sprite at (0,0), ROM row 0 → pixel (0,0) is BG (bit 63 = 0) and pixel (26,0) is FG. Toggling rst_n low mid-line forces outputs to reset values asynchronously.
